sprite_draw: RTL and testbench

- Executes the CHIP-8 DRW Vx, Vy, n operation for the cpu.
- The cpu supplies x, y, row count n and the I pointer, then waits on busy/done.
- The block fetches n sprite bytes from main memory and XORs them into the 64x32 monochrome framebuffer.
- It reports the collision flag that the cpu writes into VF.
- Sits directly downstream of the cpu; sole writer of the framebuffer RAM.

---
 rtl/chip8_pkg.sv | 32 +++
 rtl/sprite_draw.sv | 174 +++++++++++++++++
 tb/tb_sprite_draw.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display definitions: screen geometry, sprite-draw FSM encoding
// and the packing of (row, column byte) into a framebuffer byte address.
package chip8_pkg;

    localparam int SCREEN_W         = 64;
    localparam int SCREEN_H         = 32;
    localparam int FB_BYTES_PER_ROW = 8;

    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_FETCH_ENC   = 3'd1;
    localparam logic [2:0] ST_LOAD_L_ENC  = 3'd2;
    localparam logic [2:0] ST_WRITE_L_ENC = 3'd3;
    localparam logic [2:0] ST_LOAD_R_ENC  = 3'd4;
    localparam logic [2:0] ST_WRITE_R_ENC = 3'd5;
    localparam logic [2:0] ST_DONE_ENC    = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_FETCH   = ST_FETCH_ENC,
        ST_LOAD_L  = ST_LOAD_L_ENC,
        ST_WRITE_L = ST_WRITE_L_ENC,
        ST_LOAD_R  = ST_LOAD_R_ENC,
        ST_WRITE_R = ST_WRITE_R_ENC,
        ST_DONE    = ST_DONE_ENC
    } draw_state_t;

    // Row-major byte address: 8 bytes per 64-pixel row, MSB of a byte is leftmost.
    function automatic logic [7:0] fb_pack(input logic [4:0] row, input logic [2:0] col_byte);
        return {row, col_byte};
    endfunction

endpackage

// File: rtl/sprite_draw.sv
// CHIP-8 DRW: fetches n sprite bytes and XORs them into the framebuffer, reporting collision.
// Latency 3 cycles/aligned row, 5/spanning row, +1 done; no backpressure, draw ignored unless idle.
module sprite_draw
    import chip8_pkg::*;
#(
    parameter int MEM_AW = 12,
    parameter int FB_AW  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              draw,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    input  logic [3:0]        n,
    input  logic [MEM_AW-1:0] i_addr,
    output logic              busy,
    output logic              done,
    output logic              collision,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [FB_AW-1:0]  fb_addr,
    input  logic [7:0]        fb_rdata,
    output logic [7:0]        fb_wdata,
    output logic              fb_we
);

    localparam int COL_W = $clog2(SCREEN_W);
    localparam int ROW_W = $clog2(SCREEN_H);

    draw_state_t       state;
    draw_state_t       state_nxt;

    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row0_q;
    logic [3:0]        n_q;
    logic [3:0]        r_q;
    logic [MEM_AW-1:0] i_q;
    logic [2:0]        shift_q;
    logic [7:0]        spr_q;
    logic              coll_q;

    logic [5:0]        row_abs;
    logic              row_clip;
    logic [2:0]        col_byte;
    logic              need_right;
    logic              last_row;
    logic [15:0]       spr_wide;
    logic [7:0]        mask_l;
    logic [7:0]        mask_r;
    logic              unused_bits;

    assign unused_bits = ^{x[7:COL_W], y[7:ROW_W]};

    // Rows below the bottom edge are dropped, never wrapped.
    assign row_abs    = {1'b0, row0_q} + {2'b00, r_q};
    assign row_clip   = (row_abs >= 6'(SCREEN_H));
    assign col_byte   = col_q[5:3];
    assign need_right = (shift_q != 3'd0) && (col_byte != 3'(FB_BYTES_PER_ROW - 1));
    assign last_row   = (({1'b0, r_q} + 5'd1) >= {1'b0, n_q});

    // One 16-bit shift yields both halves: upper byte is s >> shift, lower is s << (8 - shift).
    assign spr_wide = {spr_q, 8'h00} >> shift_q;
    assign mask_l   = spr_wide[15:8];
    assign mask_r   = spr_wide[7:0];

    assign collision = coll_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            col_q   <= '0;
            row0_q  <= '0;
            n_q     <= '0;
            r_q     <= '0;
            i_q     <= '0;
            shift_q <= '0;
            spr_q   <= '0;
            coll_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (draw) begin
                        col_q   <= x[COL_W-1:0];
                        row0_q  <= y[ROW_W-1:0];
                        n_q     <= n;
                        i_q     <= i_addr;
                        shift_q <= x[2:0];
                        r_q     <= '0;
                        coll_q  <= 1'b0;
                    end
                end
                ST_LOAD_L: begin
                    spr_q <= mem_data;
                end
                ST_WRITE_L: begin
                    coll_q <= coll_q | (|(fb_rdata & mask_l));
                    if (!need_right && !last_row) begin
                        r_q <= r_q + 4'd1;
                    end
                end
                ST_WRITE_R: begin
                    coll_q <= coll_q | (|(fb_rdata & mask_r));
                    if (!last_row) begin
                        r_q <= r_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_addr  = '0;
        fb_addr   = '0;
        fb_wdata  = '0;
        fb_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (draw) begin
                    state_nxt = (n == 4'd0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy = 1'b1;
                if (row_clip) begin
                    state_nxt = ST_DONE;
                end else begin
                    mem_addr  = i_q + MEM_AW'(r_q);
                    state_nxt = ST_LOAD_L;
                end
            end
            ST_LOAD_L: begin
                busy      = 1'b1;
                fb_addr   = FB_AW'(fb_pack(row_abs[4:0], col_byte));
                state_nxt = ST_WRITE_L;
            end
            ST_WRITE_L: begin
                busy     = 1'b1;
                fb_addr  = FB_AW'(fb_pack(row_abs[4:0], col_byte));
                fb_wdata = fb_rdata ^ mask_l;
                fb_we    = 1'b1;
                if (need_right) begin
                    state_nxt = ST_LOAD_R;
                end else begin
                    state_nxt = last_row ? ST_DONE : ST_FETCH;
                end
            end
            ST_LOAD_R: begin
                busy      = 1'b1;
                fb_addr   = FB_AW'(fb_pack(row_abs[4:0], col_byte + 3'd1));
                state_nxt = ST_WRITE_R;
            end
            ST_WRITE_R: begin
                busy      = 1'b1;
                fb_addr   = FB_AW'(fb_pack(row_abs[4:0], col_byte + 3'd1));
                fb_wdata  = fb_rdata ^ mask_r;
                fb_we     = 1'b1;
                state_nxt = last_row ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sprite_draw.sv
// Directed bench for sprite_draw with behavioural main memory and framebuffer RAMs.
module tb_sprite_draw;

    logic        clk = 1'b0;
    logic        reset;
    logic        draw;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [3:0]  n;
    logic [11:0] i_addr;
    logic        busy;
    logic        done;
    logic        collision;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  fb_addr;
    logic [7:0]  fb_rdata;
    logic [7:0]  fb_wdata;
    logic        fb_we;

    logic [7:0]  mem [4096];
    logic [7:0]  fb  [256];
    logic [7:0]  mem_q;
    logic [7:0]  fb_q;
    logic        fb_clr;
    logic        fb_pre_we;
    logic [7:0]  fb_pre_addr;
    logic [7:0]  fb_pre_val;

    int n_checks = 0;
    int n_fail   = 0;
    int we_count = 0;
    int done_count = 0;

    always #5 clk = ~clk;

    sprite_draw #(.MEM_AW(12), .FB_AW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .draw      (draw),
        .x         (x),
        .y         (y),
        .n         (n),
        .i_addr    (i_addr),
        .busy      (busy),
        .done      (done),
        .collision (collision),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .fb_addr   (fb_addr),
        .fb_rdata  (fb_rdata),
        .fb_wdata  (fb_wdata),
        .fb_we     (fb_we)
    );

    assign mem_data = mem_q;
    assign fb_rdata = fb_q;

    always @(posedge clk) begin
        mem_q <= mem[mem_addr];
        fb_q  <= fb[fb_addr];
        if (fb_clr) begin
            for (int i = 0; i < 256; i++) fb[i] <= 8'h00;
        end else begin
            if (fb_pre_we) fb[fb_pre_addr] <= fb_pre_val;
            if (fb_we) fb[fb_addr] <= fb_wdata;
        end
    end

    always @(posedge clk) begin
        if (fb_we) we_count++;
        if (done) done_count++;
    end

    function automatic int count_nonzero();
        int c = 0;
        for (int i = 0; i < 256; i++) if (fb[i] != 8'h00) c++;
        return c;
    endfunction

    task automatic clear_fb();
        @(negedge clk); fb_clr = 1'b1;
        @(negedge clk); fb_clr = 1'b0;
    endtask

    task automatic preset_fb(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk); fb_pre_we = 1'b1; fb_pre_addr = a; fb_pre_val = v;
        @(negedge clk); fb_pre_we = 1'b0;
    endtask

    // Returns cycles from the acceptance edge to the done cycle (0 on timeout).
    task automatic run_draw(input logic [7:0] dx, input logic [7:0] dy, input logic [3:0] dn,
                            input logic [11:0] di, output int cyc, output logic coll);
        @(negedge clk); x = dx; y = dy; n = dn; i_addr = di; draw = 1'b1;
        @(posedge clk);
        @(negedge clk); draw = 1'b0;
        cyc = 0; coll = 1'bx;
        for (int k = 1; k <= 100; k++) begin
            if (done) begin cyc = k; coll = collision; break; end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL reset_collision: got %b expected 0", collision); end
        n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_fb_we: got %b expected 0", fb_we); end
        n_checks++; if (mem_addr !== 12'h000) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 000", mem_addr); end
        n_checks++; if (fb_addr !== 8'h00) begin n_fail++; $display("FAIL reset_fb_addr: got %h expected 00", fb_addr); end
        n_checks++; if (fb_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_fb_wdata: got %h expected 00", fb_wdata); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_aligned();
        int cyc; logic coll; int w0;
        clear_fb();
        w0 = we_count;
        run_draw(8'd8, 8'd0, 4'd1, 12'h200, cyc, coll);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL aligned_latency: got %0d expected 4", cyc); end
        n_checks++; if (coll !== 1'b0) begin n_fail++; $display("FAIL aligned_collision: got %b expected 0", coll); end
        n_checks++; if (fb[8'h01] !== 8'hF0) begin n_fail++; $display("FAIL aligned_fb01: got %h expected F0", fb[8'h01]); end
        n_checks++; if (count_nonzero() !== 1) begin n_fail++; $display("FAIL aligned_other_bytes: got %0d nonzero expected 1", count_nonzero()); end
        n_checks++; if (we_count - w0 !== 1) begin n_fail++; $display("FAIL aligned_we_pulses: got %0d expected 1", we_count - w0); end
    endtask

    task automatic test_erase();
        int cyc; logic coll;
        run_draw(8'd8, 8'd0, 4'd1, 12'h200, cyc, coll);
        n_checks++; if (fb[8'h01] !== 8'h00) begin n_fail++; $display("FAIL erase_fb01: got %h expected 00", fb[8'h01]); end
        n_checks++; if (coll !== 1'b1) begin n_fail++; $display("FAIL erase_collision: got %b expected 1", coll); end
        n_checks++; if (collision !== 1'b1) begin n_fail++; $display("FAIL erase_collision_held: got %b expected 1", collision); end
    endtask

    task automatic test_n_zero();
        int cyc; logic coll; int w0;
        w0 = we_count;
        run_draw(8'd5, 8'd5, 4'd0, 12'h123, cyc, coll);
        n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL nzero_latency: got %0d expected 1", cyc); end
        n_checks++; if (coll !== 1'b0) begin n_fail++; $display("FAIL nzero_collision: got %b expected 0", coll); end
        n_checks++; if (we_count - w0 !== 0) begin n_fail++; $display("FAIL nzero_we_pulses: got %0d expected 0", we_count - w0); end
    endtask

    task automatic test_span();
        int cyc; logic coll; int w0;
        clear_fb();
        w0 = we_count;
        run_draw(8'd4, 8'd2, 4'd1, 12'h300, cyc, coll);
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL span_latency: got %0d expected 6", cyc); end
        n_checks++; if (fb[8'h10] !== 8'h0F) begin n_fail++; $display("FAIL span_left: got %h expected 0F", fb[8'h10]); end
        n_checks++; if (fb[8'h11] !== 8'hF0) begin n_fail++; $display("FAIL span_right: got %h expected F0", fb[8'h11]); end
        n_checks++; if (we_count - w0 !== 2) begin n_fail++; $display("FAIL span_we_pulses: got %0d expected 2", we_count - w0); end
        n_checks++; if (coll !== 1'b0) begin n_fail++; $display("FAIL span_collision: got %b expected 0", coll); end
    endtask

    task automatic test_clip_wrap();
        int cyc; logic coll; int w0;
        clear_fb();
        w0 = we_count;
        run_draw(8'd60, 8'd31, 4'd2, 12'h400, cyc, coll);
        n_checks++; if (fb[8'hFF] !== 8'h0F) begin n_fail++; $display("FAIL clip_fbFF: got %h expected 0F", fb[8'hFF]); end
        n_checks++; if (count_nonzero() !== 1) begin n_fail++; $display("FAIL clip_other_bytes: got %0d nonzero expected 1", count_nonzero()); end
        n_checks++; if (we_count - w0 !== 1) begin n_fail++; $display("FAIL clip_we_pulses: got %0d expected 1", we_count - w0); end
        n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL clip_latency: got %0d expected 5", cyc); end
        clear_fb();
        run_draw(8'd70, 8'd33, 4'd1, 12'h410, cyc, coll);
        n_checks++; if (fb[8'h08] !== 8'h02) begin n_fail++; $display("FAIL wrap_left: got %h expected 02", fb[8'h08]); end
        n_checks++; if (fb[8'h09] !== 8'h04) begin n_fail++; $display("FAIL wrap_right: got %h expected 04", fb[8'h09]); end
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL wrap_latency: got %0d expected 6", cyc); end
    endtask

    task automatic test_multirow();
        int cyc; int w0;
        clear_fb();
        w0 = we_count;
        @(negedge clk); x = 8'd0; y = 8'd0; n = 4'd5; i_addr = 12'h050; draw = 1'b1;
        @(posedge clk);
        @(negedge clk); draw = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 2) begin draw = 1'b1; x = 8'd16; end
            if (k == 4) draw = 1'b0;
            if (done) begin cyc = k; break; end
            @(negedge clk);
        end
        @(negedge clk);
        n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL multi_latency: got %0d expected 16", cyc); end
        n_checks++; if (fb[8'h00] !== 8'hF0) begin n_fail++; $display("FAIL multi_row0: got %h expected F0", fb[8'h00]); end
        n_checks++; if (fb[8'h08] !== 8'h90) begin n_fail++; $display("FAIL multi_row1: got %h expected 90", fb[8'h08]); end
        n_checks++; if (fb[8'h10] !== 8'h90) begin n_fail++; $display("FAIL multi_row2: got %h expected 90", fb[8'h10]); end
        n_checks++; if (fb[8'h18] !== 8'h90) begin n_fail++; $display("FAIL multi_row3: got %h expected 90", fb[8'h18]); end
        n_checks++; if (fb[8'h20] !== 8'hF0) begin n_fail++; $display("FAIL multi_row4: got %h expected F0", fb[8'h20]); end
        n_checks++; if (count_nonzero() !== 5) begin n_fail++; $display("FAIL multi_other_bytes: got %0d nonzero expected 5", count_nonzero()); end
        n_checks++; if (we_count - w0 !== 5) begin n_fail++; $display("FAIL multi_we_pulses: got %0d expected 5", we_count - w0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_draw_ignored: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_draw();
        int cyc; logic coll; int d0;
        clear_fb();
        preset_fb(8'h00, 8'hFF);
        d0 = done_count;
        @(negedge clk); x = 8'd0; y = 8'd0; n = 4'd5; i_addr = 12'h050; draw = 1'b1;
        @(posedge clk);
        @(negedge clk); draw = 1'b0;
        for (int k = 1; k < 9; k++) @(negedge clk);
        n_checks++; if (fb_we !== 1'b1) begin n_fail++; $display("FAIL midrst_in_write: got fb_we %b expected 1", fb_we); end
        n_checks++; if (fb_addr !== 8'h10) begin n_fail++; $display("FAIL midrst_row2_addr: got %h expected 10", fb_addr); end
        n_checks++; if (collision !== 1'b1) begin n_fail++; $display("FAIL midrst_coll_before: got %b expected 1", collision); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL midrst_collision: got %b expected 0", collision); end
        n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL midrst_fb_we: got %b expected 0", fb_we); end
        repeat (10) @(negedge clk);
        n_checks++; if (done_count - d0 !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_count - d0); end
        n_checks++; if (fb[8'h00] !== 8'h0F) begin n_fail++; $display("FAIL midrst_row0_kept: got %h expected 0F", fb[8'h00]); end
        n_checks++; if (fb[8'h08] !== 8'h90) begin n_fail++; $display("FAIL midrst_row1_kept: got %h expected 90", fb[8'h08]); end
        n_checks++; if (fb[8'h18] !== 8'h00) begin n_fail++; $display("FAIL midrst_row3_untouched: got %h expected 00", fb[8'h18]); end
        run_draw(8'd8, 8'd0, 4'd1, 12'h200, cyc, coll);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL midrst_redraw_latency: got %0d expected 4", cyc); end
        n_checks++; if (fb[8'h01] !== 8'hF0) begin n_fail++; $display("FAIL midrst_redraw_fb01: got %h expected F0", fb[8'h01]); end
    endtask

    initial begin
        reset = 1'b1; draw = 1'b0; x = '0; y = '0; n = '0; i_addr = '0;
        fb_clr = 1'b0; fb_pre_we = 1'b0; fb_pre_addr = '0; fb_pre_val = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h200] = 8'hF0;
        mem[12'h300] = 8'hFF;
        mem[12'h400] = 8'hFF;
        mem[12'h401] = 8'hFF;
        mem[12'h410] = 8'h81;
        mem[12'h050] = 8'hF0;
        mem[12'h051] = 8'h90;
        mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90;
        mem[12'h054] = 8'hF0;

        test_reset();
        test_aligned();
        test_erase();
        test_n_zero();
        test_span();
        test_clip_wrap();
        test_multirow();
        test_reset_mid_draw();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
